// File: rtl/chip8_rom_loader.sv
// Loads a CHIP-8 program image into CPU memory over port A, then reads it back
// and compares a checksum. The CPU is held in halt for the whole sequence.
module chip8_rom_loader #(
    parameter logic [11:0] BASE_ADDR = 12'h200,
    parameter logic [12:0] MAX_LEN   = 13'd3584
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [12:0] len,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_en,
    output logic        mem_write,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        cpu_halt,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {IDLE, LOAD, VRD, VCHK, FIN} state_t;

    state_t      state_reg, state_next;
    logic [12:0] len_reg, cnt_reg;
    logic [11:0] addr_reg;
    logic [7:0]  sum_reg, vsum_reg;
    logic        rd_pend_reg, error_reg;

    logic        start_acc, wr_fire, last_wr, last_rd;
    logic [7:0]  vsum_acc;

    assign start_acc = start && (state_reg == IDLE) && !reset;
    assign wr_fire   = (state_reg == LOAD) && in_valid;
    assign last_wr   = wr_fire && ((cnt_reg + 13'd1) == len_reg);
    assign last_rd   = (state_reg == VRD) && ((cnt_reg + 13'd1) == len_reg);
    // Read data lags its issue by one cycle, so accumulation trails the address.
    assign vsum_acc  = rd_pend_reg ? (vsum_reg + mem_rdata) : vsum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_acc) begin
                    if (len == 13'd0 || len > MAX_LEN) begin
                        state_next = FIN;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD:    if (last_wr) state_next = VRD;
            VRD:     if (last_rd) state_next = VCHK;
            VCHK:    state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg == LOAD);
        mem_en    = wr_fire || (state_reg == VRD);
        mem_write = wr_fire;
        mem_addr  = addr_reg;
        mem_wdata = wr_fire ? in_data : 8'h00;
        cpu_halt  = (state_reg != IDLE) || start_acc;
        busy      = (state_reg != IDLE);
        done      = (state_reg == FIN);
        error     = error_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_reg     <= 13'd0;
            cnt_reg     <= 13'd0;
            addr_reg    <= 12'h000;
            sum_reg     <= 8'h00;
            vsum_reg    <= 8'h00;
            rd_pend_reg <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_acc) begin
                        len_reg     <= len;
                        cnt_reg     <= 13'd0;
                        addr_reg    <= BASE_ADDR;
                        sum_reg     <= 8'h00;
                        vsum_reg    <= 8'h00;
                        rd_pend_reg <= 1'b0;
                        error_reg   <= (len > MAX_LEN);
                    end
                end
                LOAD: begin
                    if (wr_fire) begin
                        sum_reg <= sum_reg + in_data;
                        if (last_wr) begin
                            addr_reg <= BASE_ADDR;
                            cnt_reg  <= 13'd0;
                            vsum_reg <= 8'h00;
                        end else begin
                            addr_reg <= addr_reg + 12'd1;
                            cnt_reg  <= cnt_reg + 13'd1;
                        end
                    end
                end
                VRD: begin
                    addr_reg    <= addr_reg + 12'd1;
                    cnt_reg     <= cnt_reg + 13'd1;
                    vsum_reg    <= vsum_acc;
                    rd_pend_reg <= 1'b1;
                end
                VCHK: begin
                    vsum_reg    <= vsum_acc;
                    rd_pend_reg <= 1'b0;
                    error_reg   <= (vsum_acc != sum_reg);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_rom_loader.sv
// Randomized bench for chip8_rom_loader: drives images, models port-A memory,
// and checks traffic and results against an image-level reference.
module tb_chip8_rom_loader;

    localparam int BASE = 'h200;
    localparam int MAXL = 3584;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready;
    logic [12:0] len;
    logic [7:0]  in_data, mem_wdata, mem_rdata;
    logic        mem_en, mem_write, cpu_halt, busy, done, error;
    logic [11:0] mem_addr;

    logic [7:0]  mem [0:4095];
    logic [7:0]  img [0:4095];
    bit          corrupt_en;
    int          n_checks, n_pass;

    always #5 clk = ~clk;

    chip8_rom_loader dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_halt(cpu_halt), .busy(busy), .done(done), .error(error)
    );

    // Write-first synchronous RAM; optional single-bit corruption on reads of 0x201.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_write) begin
                mem[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= mem[mem_addr] ^ ((corrupt_en && mem_addr == 12'h201) ? 8'h01 : 8'h00);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // mode: 0 full rate, 1 pattern 1,0,0 repeating, 2 random
    task automatic run_load(input string name, input int n, input int mode, input bit corrupt);
        int idx = 0, rd = 0, cyc = 0, done_cnt = 0, bad = 0, halt_bad = 0;
        int done_cyc = -1, last_addr = -1, mbad = 0, budget;
        int exp_wr, sum_w = 0, sum_r = 0;
        logic err_seen = 1'b0;
        bit fin = 0, exp_err;

        exp_wr = (n >= 1 && n <= MAXL) ? n : 0;
        for (int i = 0; i < exp_wr; i++) begin
            sum_w += img[i];
            sum_r += img[i] ^ ((corrupt && i == 1) ? 8'h01 : 8'h00);
        end
        exp_err = (n > MAXL) || ((sum_w % 256) != (sum_r % 256));
        budget  = 4 * n + 20;
        corrupt_en = corrupt;

        @(negedge clk);
        start = 1'b1; len = n[12:0]; in_valid = 1'b0;
        #1;
        check({name, ".halt_at_start"}, cpu_halt, 1);
        @(negedge clk);
        start = 1'b0;
        while (!fin && cyc < budget) begin
            case (mode)
                0:       in_valid = (idx < n);
                1:       in_valid = (idx < n) && (cyc % 3 == 0);
                default: in_valid = (idx < n) && ($urandom_range(0, 1) == 1);
            endcase
            in_data = (idx < 4096) ? img[idx] : 8'h00;
            #1;
            if (in_valid && in_ready) begin
                if (!(mem_en && mem_write && int'(mem_addr) == BASE + idx && mem_wdata == img[idx])) bad++;
                last_addr = int'(mem_addr);
                idx++;
            end else if (mem_en && mem_write) begin
                bad++;
            end
            if (mem_en && !mem_write) begin
                if (int'(mem_addr) != BASE + rd || idx != n) bad++;
                rd++;
            end
            if (!cpu_halt || !busy) halt_bad++;
            if (done) begin
                done_cnt++; done_cyc = cyc; err_seen = error; fin = 1;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < exp_wr; i++) if (mem[BASE + i] !== img[i]) mbad++;

        check({name, ".done_seen"}, done_cnt, 1);
        check({name, ".writes"}, idx < exp_wr ? idx : exp_wr, exp_wr);
        check({name, ".reads"}, rd, exp_wr);
        check({name, ".port_traffic"}, bad, 0);
        check({name, ".halt_busy"}, halt_bad, 0);
        check({name, ".error"}, err_seen, exp_err);
        check({name, ".mem"}, mbad, 0);
        check({name, ".idle_after"}, {done, busy, cpu_halt}, 3'b000);
        check({name, ".error_sticky"}, error, exp_err);
        if (exp_wr > 0) check({name, ".last_addr"}, last_addr, BASE + n - 1);
        else check({name, ".done_latency"}, (done_cyc == 0 || done_cyc == 1), 1);
        $display("txn %s len=%0d mode=%0d wr=%0d rd=%0d err=%0b cycles=%0d", name, n, mode, idx, rd, err_seen, cyc);
    endtask

    initial begin
        int n;
        n_checks = 0; n_pass = 0; corrupt_en = 0;
        reset = 1'b1; start = 1'b0; len = 13'd0; in_valid = 1'b0; in_data = 8'h00;
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        check("reset.outputs", {in_ready, mem_en, mem_write, cpu_halt, busy, done, error}, 7'b0);
        reset = 1'b0;

        img[0] = 8'h12; img[1] = 8'h34; img[2] = 8'hAB; img[3] = 8'hCD;
        run_load("full4", 4, 0, 0);
        run_load("toggle4", 4, 1, 0);
        run_load("len0", 0, 2, 0);
        run_load("len3585", 3585, 0, 0);
        run_load("corrupt4", 4, 0, 1);
        run_load("clear_err", 4, 2, 0);
        for (int i = 0; i < MAXL; i++) img[i] = 8'(i);
        run_load("max", MAXL, 0, 0);

        for (int t = 0; t < 5; t++) begin
            n = $urandom_range(1, 40);
            for (int i = 0; i < n; i++) img[i] = 8'($urandom);
            run_load("rand", n, 2, 0);
        end

        // Reset in the middle of a load
        img[0] = 8'h5A; img[1] = 8'hA5;
        @(negedge clk);
        start = 1'b1; len = 13'd4;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = img[0];
        @(negedge clk);
        in_data = img[1];
        @(negedge clk);
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        #1;
        check("midreset.idle", {busy, cpu_halt, done}, 3'b000);
        check("midreset.kept", {mem[BASE], mem[BASE + 1]}, {img[0], img[1]});
        reset = 1'b0;
        $display("txn midreset bytes_kept=%0h,%0h", mem[BASE], mem[BASE + 1]);
        img[0] = 8'h77;
        run_load("after_reset", 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
